// File: rtl/choose_scan_pkg.sv
// Shared types and sizes for the choose_scan address sequencer.
// Imported by the interface, the hold timer and the top.
package choose_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 2;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/choose_scan_if.sv
// Scan-control and capture bundle between a requester/4:1 mux and choose_scan.
// The master drives start/abort/M; the slave (choose_scan) drives everything else.
interface choose_scan_if;
    import choose_scan_pkg::*;

    logic              start;
    logic              abort;
    logic              M;
    logic [ADDR_W-1:0] addr;
    logic              N;
    logic [NUM_CH-1:0] data;
    logic              valid;
    logic              busy;
    logic              changed;

    modport master (
        output start, abort, M,
        input  addr, N, data, valid, busy, changed
    );

    modport slave (
        input  start, abort, M,
        output addr, N, data, valid, busy, changed
    );

endinterface

// File: rtl/choose_scan_hold_timer.sv
// Per-address settle counter: tick marks the last hold cycle (count == HOLD_CYCLES-1).
// Zero latency on tick; clr has priority over en.
module hold_timer
    import choose_scan_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + HOLD_W'(1);
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/choose_scan.sv
// Sweeps addr 0..3, samples M after HOLD_CYCLES each, emits a 4-bit word; start-to-valid 4*HOLD_CYCLES+1.
// No backpressure: start during a scan is dropped. CHOOSE_SCAN_CHANGE_DETECT_EN enables the changed flag.
module choose_scan
    import choose_scan_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    choose_scan_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic              tick;
    logic              timer_clr;
    logic              sample;
    logic              finish;
    logic [ADDR_W-1:0] addr;
    logic [NUM_CH-1:0] shadow;
    logic [NUM_CH-1:0] word;
    logic [NUM_CH-1:0] data;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (state == SCAN),
        .tick  (tick)
    );

    // Restart the settle count for every address and whenever we are not scanning.
    assign timer_clr = (state != SCAN) || tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = SCAN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    sample = 1'b1;
                    if (addr == ADDR_W'(NUM_CH - 1)) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The last channel goes straight from M into the word, never through the shadow.
    always_comb begin
        word             = shadow;
        word[NUM_CH-1]   = bus.M;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            shadow <= '0;
            data   <= '0;
        end else begin
            if (state_nxt != SCAN) begin
                addr   <= '0;
                shadow <= '0;
            end else if (sample) begin
                shadow[addr] <= bus.M;
                addr         <= addr + ADDR_W'(1);
            end
            if (finish) begin
                data <= word;
            end
        end
    end

    assign bus.addr  = addr;
    assign bus.data  = data;
    assign bus.busy  = (state == SCAN);
    assign bus.N     = (state == SCAN);
    assign bus.valid = (state == DONE);

`ifdef CHOOSE_SCAN_CHANGE_DETECT_EN
    // data itself still holds the previous word at the completing edge.
    logic changed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= finish && (word != data);
        end
    end

    assign bus.changed = changed_q;
`else
    assign bus.changed = 1'b0;
`endif

endmodule

// File: tb/tb_choose_scan.sv
// Bench for choose_scan: three instances (H=1,3,2) each fed by a 4:1 mux model.
// Stimulus pushes expected words into a scoreboard; a negedge monitor pops on valid.
module tb_choose_scan;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       start_v [3];
    logic       abort_v [3];
    logic [3:0] ain     [3];
    logic [1:0] addr_v  [3];
    logic       n_v     [3];
    logic [3:0] data_v  [3];
    logic       valid_v [3];
    logic       busy_v  [3];
    logic       chg_v   [3];
    logic [3:0] prev    [3];

    typedef struct {
        logic [3:0] data;
        logic       chg;
        int         cyc;
        int         inst;
    } exp_t;

    exp_t sb[$];

    choose_scan_if bus_h1 ();
    choose_scan_if bus_h3 ();
    choose_scan_if bus_h2 ();

    choose_scan #(.HOLD_CYCLES(1)) dut_h1 (.clk(clk), .rst_n(rst_n), .bus(bus_h1.slave));
    choose_scan #(.HOLD_CYCLES(3)) dut_h3 (.clk(clk), .rst_n(rst_n), .bus(bus_h3.slave));
    choose_scan #(.HOLD_CYCLES(2)) dut_h2 (.clk(clk), .rst_n(rst_n), .bus(bus_h2.slave));

    assign bus_h1.start = start_v[0];
    assign bus_h1.abort = abort_v[0];
    assign bus_h1.M     = bus_h1.N ? ain[0][bus_h1.addr] : 1'b0;
    assign bus_h3.start = start_v[1];
    assign bus_h3.abort = abort_v[1];
    assign bus_h3.M     = bus_h3.N ? ain[1][bus_h3.addr] : 1'b0;
    assign bus_h2.start = start_v[2];
    assign bus_h2.abort = abort_v[2];
    assign bus_h2.M     = bus_h2.N ? ain[2][bus_h2.addr] : 1'b0;

    assign addr_v[0] = bus_h1.addr;  assign addr_v[1] = bus_h3.addr;  assign addr_v[2] = bus_h2.addr;
    assign n_v[0]    = bus_h1.N;     assign n_v[1]    = bus_h3.N;     assign n_v[2]    = bus_h2.N;
    assign data_v[0] = bus_h1.data;  assign data_v[1] = bus_h3.data;  assign data_v[2] = bus_h2.data;
    assign valid_v[0]= bus_h1.valid; assign valid_v[1]= bus_h3.valid; assign valid_v[2]= bus_h2.valid;
    assign busy_v[0] = bus_h1.busy;  assign busy_v[1] = bus_h3.busy;  assign busy_v[2] = bus_h2.busy;
    assign chg_v[0]  = bus_h1.changed; assign chg_v[1] = bus_h3.changed; assign chg_v[2] = bus_h2.changed;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst %0d: got %0h expected %0h (cyc %0d)", name, inst, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int inst, input logic [3:0] d, input int at);
        logic c;
`ifdef CHOOSE_SCAN_CHANGE_DETECT_EN
        c = (d != prev[inst]);
`else
        c = 1'b0;
`endif
        prev[inst] = d;
        sb.push_back('{data: d, chg: c, cyc: at, inst: inst});
    endtask

    task automatic chk_zero(input int i);
        chk("rst_addr",    i, int'(addr_v[i]),  0);
        chk("rst_N",       i, int'(n_v[i]),     0);
        chk("rst_data",    i, int'(data_v[i]),  0);
        chk("rst_valid",   i, int'(valid_v[i]), 0);
        chk("rst_busy",    i, int'(busy_v[i]),  0);
        chk("rst_changed", i, int'(chg_v[i]),   0);
    endtask

    // Monitor: every valid pulse must match the oldest expected scan, on the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (valid_v[i]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid inst %0d: got data %b, expected no valid", i, data_v[i]);
                    end else begin
                        e = sb.pop_front();
                        chk("valid_inst",  i, i,                e.inst);
                        chk("valid_data",  i, int'(data_v[i]),  int'(e.data));
                        chk("valid_chg",   i, int'(chg_v[i]),   int'(e.chg));
                        chk("valid_cycle", i, cyc,              e.cyc);
                    end
                end else if (chg_v[i]) begin
                    checks++;
                    errors++;
                    $display("FAIL changed_no_valid inst %0d: got changed 1, expected 0", i);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
            ain[i]     = 4'b0000;
            prev[i]    = 4'b0000;
        end
        rst_n = 1'b1;
        #3 rst_n = 1'b0;

        // Reset with random inputs toggling
        repeat (4) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                start_v[i] = 1'($urandom_range(0, 1));
                abort_v[i] = 1'($urandom_range(0, 1));
                ain[i]     = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_zero(i);
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("idle_busy", i, int'(busy_v[i]), 0);
            chk("idle_addr", i, int'(addr_v[i]), 0);
        end

        // Basic scan, H=1, A0..A3 = 1,0,1,1
        @(negedge clk);
        ain[0] = 4'b1101;
        start_v[0] = 1'b1;
        push_exp(0, 4'b1101, cyc + 5);
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("h1_addr", 0, int'(addr_v[0]), k);
            chk("h1_N",    0, int'(n_v[0]),    1);
            @(negedge clk);
        end
        chk("h1_done_N",    0, int'(n_v[0]),    0);
        chk("h1_done_busy", 0, int'(busy_v[0]), 0);
        chk("h1_done_addr", 0, int'(addr_v[0]), 0);
        repeat (2) @(negedge clk);

        // Hold timing, H=3, A0..A3 = 0,1,1,0
        ain[1] = 4'b0110;
        start_v[1] = 1'b1;
        push_exp(1, 4'b0110, cyc + 13);
        @(negedge clk);
        start_v[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("h3_addr", 1, int'(addr_v[1]), k / 3);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Abort, H=2: first a full scan to load 1101
        ain[2] = 4'b1101;
        start_v[2] = 1'b1;
        push_exp(2, 4'b1101, cyc + 9);
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (10) @(negedge clk);
        ain[2] = 4'b0010;
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        for (int w = 0; w < 20 && addr_v[2] != 2'd2; w++) @(negedge clk);
        chk("abort_reach_addr2", 2, int'(addr_v[2]), 2);
        abort_v[2] = 1'b1;
        @(negedge clk);
        abort_v[2] = 1'b0;
        chk("abort_busy", 2, int'(busy_v[2]), 0);
        chk("abort_N",    2, int'(n_v[2]),    0);
        chk("abort_addr", 2, int'(addr_v[2]), 0);
        chk("abort_data", 2, int'(data_v[2]), 4'b1101);
        repeat (10) @(negedge clk);
        chk("abort_data_hold", 2, int'(data_v[2]), 4'b1101);

        // Reset mid-scan on H=1 at addr=1
        ain[0] = 4'b0111;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("midrst_addr1", 0, int'(addr_v[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero(0);
        chk("midrst_data_h2", 2, int'(data_v[2]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) prev[i] = 4'b0000;
        @(negedge clk);
        ain[0] = 4'b0110;
        start_v[0] = 1'b1;
        push_exp(0, 4'b0110, cyc + 5);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);

        // Back-to-back with start held: 1101, 1000, then an unchanged 1000
        ain[0] = 4'b1101;
        start_v[0] = 1'b1;
        push_exp(0, 4'b1101, cyc + 5);
        push_exp(0, 4'b1000, cyc + 10);
        push_exp(0, 4'b1000, cyc + 15);
        repeat (5) @(negedge clk);
        ain[0] = 4'b1000;
        repeat (7) @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);

        chk("scoreboard_drained", 0, sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/choose_scan.md
# choose_scan

Sequential address sequencer that sits directly upstream of the 4:1 `choose` multiplexer. On a start request it sweeps `addr` through 0→1→2→3, holds each address for a programmable settle time, samples the multiplexer output `M`, and assembles the four samples into one 4-bit word with a one-cycle valid pulse. It turns the purely combinational selector into a scanned, registered 4-channel reader.

## Interface
- `HOLD_CYCLES`, default 1: cycles each address is held before sampling; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `start`  in  1  scan request, sampled on the rising edge.
- `abort`  in  1  synchronous scan cancel.
- `M`  in  1  multiplexer output being scanned.
- `addr`  out  2  select driven to the multiplexer.
- `N`  out  1  multiplexer enable; high only while scanning.
- `data`  out  4  captured word; bit k holds `M` sampled at `addr`=k.
- `valid`  out  1  one-cycle pulse when `data` is updated.
- `busy`  out  1  high while a scan is in progress.
- `changed`  out  1  change flag; see Configuration.
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: `addr`=0, `N`=0, `busy`=0. If `start`=1 and `abort`=0, go to SCAN with `addr`=0, hold counter=0.
- SCAN: `N`=1, `busy`=1. The hold counter increments each cycle. When the counter reaches HOLD_CYCLES-1, the edge writes `M` into shadow bit `addr` and clears the counter.
  - If `addr`≠3, `addr` increments.
  - If `addr`=3, the shadow is copied to `data` (bit 3 taken directly from `M`), and the FSM goes to DONE.
- DONE: `valid`=1, `N`=0, `busy`=0, `addr`=0. The next state is SCAN if `start`=1 and `abort`=0; otherwise IDLE. Back-to-back scans have no idle gap.
- `start` during SCAN is ignored; no queueing.
- `abort`=1 in SCAN: go to IDLE on the next edge. No `valid`; `data` is unchanged and the shadow is discarded.
- `abort` and `start` together in IDLE/DONE: `abort` wins and the FSM stays or goes to IDLE.
- `data` changes only on a completed scan.

## Timing
- Reset values: `addr`=0, `N`=0, `data`=4'b0000, `valid`=0, `busy`=0, `changed`=0, FSM=IDLE, counter=0, shadow=0.
- `rst_n` asserted mid-scan forces all reset values immediately, with no valid.
- `start` is accepted at edge T0. Samples are taken at edges T0+H, T0+2H, T0+3H, T0+4H, where H=HOLD_CYCLES.
- `valid` and the new `data` are visible in the cycle after edge T0+4H. Latency from start to valid is 4H+1 cycles.
- Outputs are registered; no combinational path from `M`/`start` to any output.
- `M` must be stable in the last hold cycle of each address.

## Configuration
- Macro `CHOOSE_SCAN_CHANGE_DETECT_EN`.
- Defined: a register holds the previous `data`. `changed`=1 in the same cycle as `valid` when the new `data` differs from the previous `data`. The previous value after reset is 4'b0000.
- Undefined: `changed` is tied 0 and the compare register is absent. The port list is identical in both builds.

## Structure
- Package `choose_scan_pkg` holds:
  - the state enum (IDLE, SCAN, DONE);
  - `NUM_CH`=4 and `ADDR_W`=2;
  - `HOLD_W`=8, the counter width.
- Sub-module `hold_timer`: an 8-bit counter with `clr` and `en` inputs, a `HOLD_CYCLES` parameter, and a `tick` output when the count equals HOLD_CYCLES-1.
- The FSM, shadow register and change-detect logic stay in the top.

## Test plan
- Reset: drive `rst_n`=0 with random inputs → all outputs at reset values; after release, the block stays in IDLE with `busy`=0.
- Basic scan: H=1, mux inputs A0..A3=1,0,1,1, one-cycle `start` → `addr` sequence 0,1,2,3; `data`=4'b1101; `valid` high for exactly 1 cycle, 5 cycles after start; `N` high for 4 cycles.
- Hold timing: H=3, A0..A3=0,1,1,0 → each address held 3 cycles; `data`=4'b0110; `valid` 13 cycles after start.
- Abort: H=2, start, then `abort` during `addr`=2 → IDLE next edge, no `valid`, `data` keeps the previous 4'b1101.
- Back-to-back: `start` held high, inputs changed between scans from 1011 to 0001 → consecutive `valid` pulses 5 cycles apart (H=1), with `data` 4'b1101 then 4'b1000. With the macro defined, `changed`=1 on both pulses; with an unchanged repeat scan, `changed`=0.
- Reset mid-scan: `rst_n` pulsed low at `addr`=1 → outputs clear asynchronously, no `valid`; a fresh start then completes normally.
